// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-32 subset core sharing one valid/ready memory port
// between instruction fetch and data access.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [3:0]  state_out,
  output logic        retire,
  output logic        halted
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  EXEC   = 4'd2,  ALUWB  = 4'd3,
    MEMADR = 4'd4,  MEMRD  = 4'd5,  MEMWB  = 4'd6,  MEMWR  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    HALT   = 4'd15
  } state_t;
  state_t state, state_nx, ill_nx;
  logic [31:0] pc, ir, a, b, alu_out, mdr, simm, alu_r, wd;
  logic [31:0] regs [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wa;
  logic we, illegal_op, illegal_fn;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign fn = ir[5:0];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign illegal_op = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
  assign illegal_fn = !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
  assign ill_nx = HALT_ON_ILLEGAL ? HALT : FETCH;
  assign alu_r = fn == 6'h20 ? a + b :
                 fn == 6'h22 ? a - b :
                 fn == 6'h24 ? a & b :
                 fn == 6'h25 ? a | b :
                 {31'd0, $signed(a) < $signed(b)};
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = mem_ready ? DECODE : FETCH;
      DECODE:  state_nx = op == 6'h00 ? EXEC :
                          (op == 6'h23 || op == 6'h2B) ? MEMADR :
                          op == 6'h04 ? BRANCH :
                          op == 6'h08 ? ADDIEX :
                          op == 6'h02 ? JUMP : ill_nx;
      EXEC:    state_nx = illegal_fn ? ill_nx : ALUWB;
      MEMADR:  state_nx = op == 6'h23 ? MEMRD : MEMWR;
      MEMRD:   state_nx = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_nx = mem_ready ? FETCH : MEMWR;
      ADDIEX:  state_nx = ADDIWB;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end
  assign we = state inside {ALUWB, MEMWB, ADDIWB};
  assign wa = state == ALUWB ? rd : rt;
  assign wd = state == MEMWB ? mdr : alu_out;
  // Gating with reset_n keeps the request low while reset is held, even though state is FETCH.
  assign mem_req   = reset_n && (state inside {FETCH, MEMRD, MEMWR});
  assign mem_we    = state == MEMWR;
  assign mem_addr  = state == FETCH ? pc : alu_out;
  assign mem_wdata = b;
  assign dbg_data  = regs[dbg_addr];
  assign pc_out    = pc;
  assign instr_out = ir;
  assign state_out = state;
  assign halted    = state == HALT;
  assign retire    = (state inside {ALUWB, MEMWB, BRANCH, ADDIWB, JUMP}) ||
                     (state == MEMWR && mem_ready) ||
                     (!HALT_ON_ILLEGAL && ((state == DECODE && illegal_op) || (state == EXEC && illegal_fn)));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && mem_ready) begin
        ir <= mem_rdata;
        pc <= pc + 32'd4;
      end
      if (state == DECODE) begin
        a       <= regs[rs];
        b       <= regs[rt];
        alu_out <= pc + {simm[29:0], 2'b00};
      end
      if (state == EXEC) alu_out <= alu_r;
      if (state == MEMADR || state == ADDIEX) alu_out <= a + simm;
      if (state == MEMRD && mem_ready) mdr <= mem_rdata;
      if (state == BRANCH && a == b) pc <= alu_out;
      if (state == JUMP) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (we && wa != 5'd0) regs[wa] <= wd;
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed and random programs against an instruction-level model;
// a second core instance exercises the illegal-as-NOP mode.
module tb_mips_multicycle_core;
  logic clk = 1'b0, reset_n = 1'b0, reset_n1 = 1'b0;
  always #5 clk = ~clk;
  logic        mem_req, mem_we, mem_ready = 1'b0, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, dbg_data, pc_out, instr_out;
  logic [4:0]  dbg_addr = '0;
  logic [3:0]  state_out;
  logic        mem_req1, mem_we1, mem_ready1 = 1'b0, retire1, halted1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1 = '0, dbg_data1, pc_out1, instr_out1;
  logic [4:0]  dbg_addr1 = '0;
  logic [3:0]  state_out1;

  mips_multicycle_core #(.RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc_out(pc_out), .instr_out(instr_out), .state_out(state_out),
    .retire(retire), .halted(halted));
  mips_multicycle_core #(.RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .dbg_addr(dbg_addr1),
    .dbg_data(dbg_data1), .pc_out(pc_out1), .instr_out(instr_out1), .state_out(state_out1),
    .retire(retire1), .halted(halted1));

  logic [31:0] mem [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] mr [32];
  int n_chk = 0, n_fail = 0;
  int waits_fixed = 0, wait_left = -1, wait_total = 0, w_mark = 0;
  bit rand_waits = 1'b0, hold_low = 1'b0;

  // Memory for the main core: fixed or random wait states; ready toggles randomly while idle.
  always @(negedge clk) begin
    if (mem_req && !hold_low) begin
      if (wait_left < 0) wait_left = rand_waits ? int'($urandom_range(0, 2)) : waits_fixed;
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        wait_left = -1;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_left--;
        wait_total++;
      end
    end else begin
      mem_ready = mem_req ? 1'b0 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      wait_left = -1;
    end
  end

  always @(negedge clk) begin
    mem_ready1 = mem_req1;
    mem_rdata1 = mem1[mem_addr1[11:2]];
    if (mem_req1 && mem_we1) mem1[mem_addr1[11:2]] = mem_wdata1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_addr = 5'(r);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Called at the first FETCH sample of an instruction; returns at the next instruction's first sample.
  task automatic run_instr(input int nxt_waits, output int lat, output int wts, output int wc,
                           output logic [31:0] wad, output logic [31:0] wdv, output bit ws);
    lat = 1;
    wc = 0;
    ws = 1'b1;
    wad = '0;
    wdv = '0;
    while (1) begin
      if (mem_req && mem_we) begin
        if (wc == 0) begin
          wad = mem_addr;
          wdv = mem_wdata;
        end else if (mem_addr !== wad || mem_wdata !== wdv) ws = 1'b0;
        wc++;
      end
      if (retire === 1'b1 || lat >= 100) break;
      step();
      lat++;
    end
    chk("retire_seen", {31'd0, retire}, 32'd1);
    wts = wait_total - w_mark;
    w_mark = wait_total;
    waits_fixed = nxt_waits;
    step();
  endtask

  function automatic logic [31:0] gen();
    logic [4:0] s, t, d;
    logic [5:0] f;
    int k;
    s = 5'($urandom_range(0, 15));
    t = 5'($urandom_range(0, 15));
    d = 5'($urandom_range(0, 15));
    k = $urandom_range(0, 8);
    f = k == 0 ? 6'h20 : k == 1 ? 6'h22 : k == 2 ? 6'h24 : k == 3 ? 6'h25 : 6'h2A;
    if (k < 5) return {6'h00, s, t, d, 5'd0, f};
    if (k == 5) return {6'h08, s, t, 16'($urandom)};
    if (k == 6) return {6'h23, 5'd0, t, 16'(32'h800 + 4 * $urandom_range(0, 63))};
    if (k == 7) return {6'h2B, 5'd0, t, 16'(32'h800 + 4 * $urandom_range(0, 63))};
    if ($urandom_range(0, 1) == 1) t = s;
    return {6'h04, s, t, 16'($urandom_range(0, 3))};
  endfunction

  int d_lat [17] = '{4, 4, 4, 4, 4, 3, 3, 10, 11, 3, 4, 4, 4, 4, 4, 3, 3};
  int d_w   [17] = '{0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  int d_r   [17] = '{8, 9, 10, 11, 0, 8, 12, 8, 12, 12, 8, 9, 10, 11, 0, 8, 12};
  logic [31:0] d_pc [17] = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h20, 32'h24, 32'h28,
                             32'h2C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h20, 32'h2C};
  logic [31:0] d_v [17] = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1, 32'd0, 32'd5, 32'd0, 32'd5,
                            32'd5, 32'd5, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1, 32'd0, 32'd5, 32'd5};

  initial begin
    int lat, wts, wc, cnt, base, diffs;
    logic [31:0] wad, wdv, ins, mpc, npc, simm, val, addr;
    logic [5:0] op;
    logic [4:0] s, t, d, dest;
    bit ws, saw_retire;
    for (int k = 0; k < 1024; k++) begin
      mem[k] = '0;
      mem1[k] = '0;
    end
    mem[64] = {6'h08, 5'd0, 5'd8, 16'd5};
    mem[65] = {6'h08, 5'd0, 5'd9, 16'hFFFD};
    mem[66] = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    mem[67] = {6'h00, 5'd9, 5'd8, 5'd11, 5'd0, 6'h2A};
    mem[68] = {6'h00, 5'd8, 5'd8, 5'd0, 5'd0, 6'h20};
    mem[69] = {6'h02, 26'h8};
    mem[8]  = {6'h04, 5'd8, 5'd12, 16'd2};
    mem[9]  = {6'h2B, 5'd0, 5'd8, 16'h10};
    mem[10] = {6'h23, 5'd0, 5'd12, 16'h10};
    mem[11] = {6'h02, 26'h40};
    step();
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_state", {28'd0, state_out}, 32'd0);
    chk("rst_ir", instr_out, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    w_mark = wait_total;
    step();
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    chk("first_we", {31'd0, mem_we}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      run_instr(i < 16 ? d_w[i + 1] : 0, lat, wts, wc, wad, wdv, ws);
      chk("dir_lat", lat, d_lat[i]);
      chk("dir_pc", pc_out, d_pc[i]);
      chk_reg("dir_reg", d_r[i], d_v[i]);
      if (i == 7) begin
        chk("sw_cycles", wc, 4);
        chk("sw_addr", wad, 32'h10);
        chk("sw_wdata", wdv, 32'd5);
        chk("sw_stable", {31'd0, ws}, 32'd1);
        chk("sw_mem", mem[4], 32'd5);
      end
    end

    // Reset while a load is stalled waiting for memory.
    reset_n = 1'b0;
    mem[64] = {6'h23, 5'd0, 5'd13, 16'h10};
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    cnt = 0;
    while (state_out !== 4'd4 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("reach_memadr", {28'd0, state_out}, 32'd4);
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("stall_state", {28'd0, state_out}, 32'd5);
    chk("stall_req", {31'd0, mem_req}, 32'd1);
    chk("stall_addr", mem_addr, 32'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_pc", pc_out, 32'h100);
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_state", {28'd0, state_out}, 32'd0);
    hold_low = 1'b0;

    for (int k = 0; k < 200; k++) mem[64 + k] = gen();
    for (int k = 0; k < 64; k++) mem[512 + k] = $urandom;
    ref_mem = mem;
    for (int k = 0; k < 32; k++) mr[k] = '0;
    rand_waits = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    w_mark = wait_total;
    step();
    chk("restart_addr", mem_addr, 32'h100);
    chk("restart_req", {31'd0, mem_req}, 32'd1);
    chk_reg("restart_r13", 13, 32'd0);
    mpc = 32'h100;
    for (int i = 0; i < 40; i++) begin
      ins = ref_mem[mpc[11:2]];
      op = ins[31:26];
      s = ins[25:21];
      t = ins[20:16];
      d = ins[15:11];
      simm = {{16{ins[15]}}, ins[15:0]};
      npc = mpc + 4;
      dest = '0;
      val = '0;
      base = 4;
      addr = mr[s] + simm;
      case (op)
        6'h00: begin
          dest = d;
          case (ins[5:0])
            6'h20: val = mr[s] + mr[t];
            6'h22: val = mr[s] - mr[t];
            6'h24: val = mr[s] & mr[t];
            6'h25: val = mr[s] | mr[t];
            default: val = ($signed(mr[s]) < $signed(mr[t])) ? 32'd1 : 32'd0;
          endcase
        end
        6'h08: begin
          dest = t;
          val = addr;
        end
        6'h23: begin
          dest = t;
          val = ref_mem[addr[11:2]];
          base = 5;
        end
        6'h2B: ref_mem[addr[11:2]] = mr[t];
        default: begin
          base = 3;
          if (mr[s] == mr[t]) npc = mpc + 4 + (simm << 2);
        end
      endcase
      if (dest != 0) mr[dest] = val;
      if (i == 39) mem[npc[11:2]] = 32'hFC00_0000;
      run_instr(0, lat, wts, wc, wad, wdv, ws);
      chk("rnd_lat", lat, base + wts);
      chk("rnd_pc", pc_out, npc);
      chk("rnd_ir", instr_out, ins);
      chk_reg("rnd_reg", int'(dest), mr[dest]);
      mpc = npc;
    end

    cnt = 0;
    saw_retire = 1'b0;
    while (halted !== 1'b1 && cnt < 20) begin
      saw_retire |= (retire === 1'b1);
      step();
      cnt++;
    end
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_state", {28'd0, state_out}, 32'd15);
    chk("ill_no_retire", {31'd0, saw_retire}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_req", {31'd0, mem_req}, 32'd0);
      chk("halt_retire", {31'd0, retire}, 32'd0);
    end
    for (int r = 0; r < 32; r++) chk_reg("final_reg", r, mr[r]);
    diffs = 0;
    for (int k = 512; k < 576; k++) if (mem[k] !== ref_mem[k]) diffs++;
    chk("dmem_diffs", diffs, 0);

    // Illegal opcode and illegal funct retire as NOPs on the second core.
    mem1[64] = 32'hFC00_0000;
    mem1[65] = {6'h00, 5'd8, 5'd8, 5'd8, 5'd0, 6'h3F};
    mem1[66] = {6'h08, 5'd0, 5'd8, 16'd7};
    mem1[67] = {6'h02, 26'h40};
    @(posedge clk);
    #1 reset_n1 = 1'b1;
    step();
    chk("nop_first_addr", mem_addr1, 32'h100);
    step();
    chk("nop_op_retire", {31'd0, retire1}, 32'd1);
    chk("nop_halted", {31'd0, halted1}, 32'd0);
    step();
    chk("nop_next_req", {31'd0, mem_req1}, 32'd1);
    chk("nop_next_addr", mem_addr1, 32'h104);
    step();
    step();
    chk("nop_fn_retire", {31'd0, retire1}, 32'd1);
    step();
    chk("nop_fn_next", mem_addr1, 32'h108);
    for (int k = 0; k < 4; k++) step();
    dbg_addr1 = 5'd8;
    #1;
    chk("nop_r8", dbg_data1, 32'd7);
    chk("nop_j_addr", mem_addr1, 32'h10C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
